// File: rtl/rock_pool_mgr_pkg.sv
// Shared types and helpers for the rock pool: LFSR shape, direction-code mapping, FSM states.
package rocks_pkg;

    localparam int              LFSR_W    = 16;
    // Feedback taps at bit positions 15, 13, 12, 10 (x^16 + x^14 + x^13 + x^11 + 1)
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
    localparam int              DIR_W     = 3;

    typedef enum logic {IDLE, FIRE} pool_state_e;

    function automatic logic [DIR_W-1:0] dir_code(input logic [LFSR_W-1:0] q);
        return {q[2], q[1], ~q[1] | q[0]};
    endfunction

endpackage

// File: rtl/rock_pool_mgr_if.sv
// Bus between the rock pool manager, the collision detector and the per-rock motion instances.
interface rock_pool_mgr_if import rocks_pkg::*; #(
    parameter int NUM_ROCKS = 10,
    parameter int COORD_W   = 10
);
    logic                 enable;
    logic [NUM_ROCKS-1:0] hit;
    logic [NUM_ROCKS-1:0] done;
    logic [NUM_ROCKS-1:0] fire;
    logic [COORD_W-1:0]   spawn_x;
    logic [COORD_W-1:0]   spawn_y;
    logic [DIR_W-1:0]     dir_x;
    logic [DIR_W-1:0]     dir_y;
    logic [NUM_ROCKS-1:0] in_use;
    logic [4:0]           active_cnt;
    logic                 pool_full;
    logic [15:0]          hit_cnt;

    modport master (
        output enable, hit, done,
        input  fire, spawn_x, spawn_y, dir_x, dir_y, in_use, active_cnt, pool_full, hit_cnt
    );

    modport slave (
        input  enable, hit, done,
        output fire, spawn_x, spawn_y, dir_x, dir_y, in_use, active_cnt, pool_full, hit_cnt
    );
endinterface

// File: rtl/rock_pool_mgr_lfsr16.sv
// 16-bit Fibonacci LFSR that advances only while en is high; reloads SEED on reset.
module lfsr16 import rocks_pkg::*; #(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic              clk60hz,
    input  logic              resetn,
    input  logic              en,
    output logic [LFSR_W-1:0] q
);

    always_ff @(posedge clk60hz) begin
        if (!resetn)
            q <= SEED;
        else if (en)
            q <= {q[LFSR_W-2:0], ^(q & LFSR_TAPS)};
    end

endmodule

// File: rtl/rock_pool_mgr.sv
// Rock slot allocator: periodic spawn into the lowest free slot, one queued spawn when full,
// occupancy tracking from hit/done pulses, and a saturating hit counter.
module rock_pool_mgr import rocks_pkg::*; #(
    parameter int          NUM_ROCKS   = 10,
    parameter int          SPAWN_TICKS = 120,
    parameter int          COORD_W     = 10,
    parameter logic [15:0] SEED_X      = 16'hACE1,
    parameter logic [15:0] SEED_Y      = 16'h1D2B
) (
    input  logic           clk60hz,
    input  logic           resetn,
    rock_pool_mgr_if.slave bus
);

    localparam int TICK_W = $clog2(SPAWN_TICKS);

    typedef logic [NUM_ROCKS-1:0] slot_t;

    // Scanning downward lets the lowest free index overwrite any higher one.
    function automatic slot_t lowest_free(input slot_t used);
        slot_t sel;
        sel = '0;
        for (int i = NUM_ROCKS - 1; i >= 0; i--)
            if (!used[i]) sel = slot_t'(1) << i;
        return sel;
    endfunction

    function automatic logic [4:0] popcount(input slot_t v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < NUM_ROCKS; i++)
            n = n + 5'(v[i]);
        return n;
    endfunction

    logic [TICK_W-1:0] tick_q;
    logic              pending_q;
    pool_state_e       state_q;
    slot_t             in_use_q;
    slot_t             fire_q;
    logic [4:0]        active_cnt_q;
    logic              pool_full_q;
    logic [15:0]       hit_cnt_q;

    logic              spawn_req;
    logic              go;
    slot_t             kept;
    slot_t             pick;
    slot_t             in_use_nx;
    logic [4:0]        n_hits;
    logic [16:0]       hit_sum;
    logic [LFSR_W-1:0] lfsr_x;
    logic [LFSR_W-1:0] lfsr_y;

    lfsr16 #(.SEED(SEED_X)) u_lfsr_x (.clk60hz(clk60hz), .resetn(resetn), .en(bus.enable), .q(lfsr_x));
    lfsr16 #(.SEED(SEED_Y)) u_lfsr_y (.clk60hz(clk60hz), .resetn(resetn), .en(bus.enable), .q(lfsr_y));

    assign spawn_req = bus.enable && (tick_q == TICK_W'(SPAWN_TICKS - 1));

    // Clears land before selection so a slot freed this cycle can be refired immediately.
    assign kept      = in_use_q & ~(bus.hit | bus.done);
    assign pick      = lowest_free(kept);
    assign go        = bus.enable && (state_q == IDLE) && (spawn_req || pending_q) && (kept != '1);
    assign in_use_nx = go ? (kept | pick) : kept;

    // Hits only count against slots that were occupied going into this cycle.
    assign n_hits    = popcount(bus.hit & in_use_q);
    assign hit_sum   = {1'b0, hit_cnt_q} + 17'(n_hits);

    always_ff @(posedge clk60hz) begin
        if (!resetn) begin
            tick_q       <= '0;
            pending_q    <= 1'b0;
            state_q      <= IDLE;
            in_use_q     <= '0;
            fire_q       <= '0;
            active_cnt_q <= '0;
            pool_full_q  <= 1'b0;
            hit_cnt_q    <= '0;
        end else begin
            if (bus.enable)
                tick_q <= spawn_req ? '0 : tick_q + 1'b1;

            case (state_q)
                IDLE:    state_q <= go ? FIRE : IDLE;
                default: state_q <= IDLE;
            endcase

            fire_q       <= go ? pick : '0;
            in_use_q     <= in_use_nx;
            active_cnt_q <= popcount(in_use_nx);
            pool_full_q  <= (in_use_nx == '1);

            // One request can wait; further requests while waiting are dropped.
            if (go)
                pending_q <= 1'b0;
            else if (spawn_req)
                pending_q <= 1'b1;

            hit_cnt_q <= hit_sum[16] ? 16'hFFFF : hit_sum[15:0];
        end
    end

    assign bus.fire       = fire_q;
    assign bus.in_use     = in_use_q;
    assign bus.active_cnt = active_cnt_q;
    assign bus.pool_full  = pool_full_q;
    assign bus.hit_cnt    = hit_cnt_q;
    assign bus.spawn_x    = lfsr_x[COORD_W-1:0];
    assign bus.spawn_y    = lfsr_y[COORD_W-1:0];
    assign bus.dir_x      = dir_code(lfsr_x);
    assign bus.dir_y      = dir_code(lfsr_y);

endmodule
